wb_arbiter2: RTL
================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter: memcontrol (master 0) and a second bus master share a single wb_ram.
- Second master is a boot loader, DMA or debug port.
- Round-robin grant, held for the full cyc of the owning master; muxes the owner onto the slave and routes responses back.
- Bus watchdog terminates stalled strobes with err.

Parameters:
DATA_WIDTH, 128, width of dat buses
ADDR_WIDTH, 16, width of adr
SEL_WIDTH, 16, width of sel (DATA_WIDTH/8)
TIMEOUT, 255, max cycles a strobe may wait for ack/err/rty; 0 disables watchdog

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
m0_adr_i, m1_adr_i  in  ADDR_WIDTH  master address
m0_dat_i, m1_dat_i  in  DATA_WIDTH  master write data
m0_dat_o, m1_dat_o  out  DATA_WIDTH  read data (broadcast of s_dat_i)
m0_we_i, m1_we_i  in  1  write enable
m0_sel_i, m1_sel_i  in  SEL_WIDTH  byte selects
m0_stb_i, m1_stb_i  in  1  strobe
m0_cyc_i, m1_cyc_i  in  1  cycle / bus request
m0_ack_o, m1_ack_o  out  1  ack
m0_err_o, m1_err_o  out  1  error
m0_rty_o, m1_rty_o  out  1  retry
s_adr_o  out  ADDR_WIDTH  to slave
s_dat_o  out  DATA_WIDTH  to slave
s_dat_i  in  DATA_WIDTH  from slave
s_we_o  out  1  to slave
s_sel_o  out  SEL_WIDTH  to slave
s_stb_o  out  1  to slave
s_cyc_o  out  1  to slave
s_ack_i  in  1  from slave
s_err_i  in  1  from slave
s_rty_i  in  1  from slave
gnt_o  out  2  one-hot current owner; 00 = idle

Behaviour:
- States: IDLE, OWN0, OWN1 (registered); last-owner bit `last` (registered); watchdog counter `wd`, width clog2(TIMEOUT+1).
- Reset (rst_n low at an edge): state IDLE, last=1 (m0 favoured next), wd=0.
  - All outputs are decoded from state, so one cycle after the reset edge: s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o = 0; all mN_ack/err/rty = 0; gnt_o = 00.
  - Reset mid-transfer drops the slave cycle with no response to the master.
- Arbitration is evaluated at every edge where state is IDLE, or the owner's cyc_i is low.
  - Only one mN_cyc_i high: grant it.
  - Both high: grant the master that is not `last`.
  - Neither high: IDLE.
  - On grant, set last = granted index.
- Owner keeps the grant while its cyc_i is high; no preemption.
- Handover: the owner drops cyc in cycle n and the other master's cyc is high in cycle n → the other master owns from cycle n+1. No idle cycle.
- Grant latency: request at cycle n, slave sees cyc/stb at cycle n+1.
- Slave mux when OWNk:
  - s_* = mk_* (combinational).
  - s_cyc_o = mk_cyc_i.
  - s_stb_o = mk_stb_i & mk_cyc_i.
  - IDLE drives zeros.
- Responses:
  - mk_ack_o = s_ack_i & s_stb_o when OWNk; err and rty gated the same way.
  - The non-owner always sees ack/err/rty = 0.
  - mN_dat_o = s_dat_i to both masters.
- Watchdog (TIMEOUT>0):
  - wd increments each cycle s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - wd clears on any response, when s_stb_o=0, or on a state change.
  - In the cycle wd==TIMEOUT with no slave response: owner's err_o=1 for that cycle, s_stb_o forced 0 for that cycle, wd clears.
  - Slave response in the same cycle wd==TIMEOUT: the slave response wins, no err.
- TIMEOUT=0: wd held at 0, err is only passed through from the slave.
- Slave asserting ack while s_stb_o=0: ignored, not forwarded.

Decomposition:
- Shared package wb_pkg: state encoding (IDLE/OWN0/OWN1) and the default Wishbone widths (128/16/16).
- One sub-module, wb_watchdog: counter, TIMEOUT parameter, inputs stb/resp, output expire.
- Mux and FSM stay in wb_arbiter2.

Test Plan:
- Reset then m0 cyc/stb write adr=0x0010, dat=0xDEADBEEF…, sel=FFFF → gnt_o=01 next cycle; slave sees the write; m0_ack_o pulses with wb_ram ack; m1 never sees ack.
- m0 and m1 raise cyc in the same cycle after reset → m0 granted first. m0 drops cyc → m1 granted the next cycle with no idle gap. Both re-request → m0 wins (round-robin).
- m1 owns and holds cyc for 4 back-to-back reads (adr 0x20..0x23); m0 requests throughout → gnt_o stays 10 until m1 drops cyc; m0 reads return the data m1 wrote.
- Slave ack stubbed to 0, TIMEOUT=8, m0 strobes → m0_err_o=1 exactly 8 cycles after stb, s_stb_o=0 that cycle; with TIMEOUT=0 no err ever.
- rst_n driven low while m1 owns mid-strobe → next cycle s_cyc_o=0, gnt_o=00, no ack/err. After release, pending m0 and m1 requests → m0 granted.
- Slave ack arrives in the same cycle wd==TIMEOUT → ack forwarded, err stays 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter:
// ownership state encoding and the default bus widths.
package wb_pkg;

   localparam int WB_DATA_WIDTH = 128;
   localparam int WB_ADDR_WIDTH = 16;
   localparam int WB_SEL_WIDTH  = 16;

   // One-hot owner encoding so the state doubles as the grant vector.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OWN0 = 2'b01;
   localparam logic [1:0] ST_OWN1 = 2'b10;

   function automatic int wd_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles a strobe waits for a slave response and
// flags expiry in the cycle the count reaches TIMEOUT.
module wb_watchdog
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_stb,
   input  logic i_resp,
   input  logic i_clr,
   output logic o_expire
);

   localparam int              WD_W   = wd_width(TIMEOUT);
   localparam bit              WD_EN  = (TIMEOUT > 0);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

   logic [WD_W-1:0] r_wd;

   // A slave response in the expiry cycle takes precedence over the timeout.
   always_comb begin
      if (WD_EN) begin
         o_expire = i_stb & ~i_resp & (r_wd == WD_MAX);
      end else begin
         o_expire = 1'b0;
      end
   end

   // Wait counter, restarted by any response, idle strobe, owner change or expiry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wd <= '0;
      end else if (!WD_EN || i_clr || !i_stb || i_resp || o_expire) begin
         r_wd <= '0;
      end else begin
         r_wd <= r_wd + WD_ONE;
      end
   end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone arbiter: round-robin grant held for the
// owner's whole cycle, owner muxed onto the slave, responses routed back.
module wb_arbiter2
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int SEL_WIDTH  = WB_SEL_WIDTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   input  logic                  m0_we_i,
   input  logic [SEL_WIDTH-1:0]  m0_sel_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_cyc_i,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   output logic                  m0_rty_o,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   input  logic                  m1_we_i,
   input  logic [SEL_WIDTH-1:0]  m1_sel_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_cyc_i,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic                  m1_rty_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   output logic                  s_we_o,
   output logic [SEL_WIDTH-1:0]  s_sel_o,
   output logic                  s_stb_o,
   output logic                  s_cyc_o,
   input  logic                  s_ack_i,
   input  logic                  s_err_i,
   input  logic                  s_rty_i,
   output logic [1:0]            gnt_o
);

   logic [1:0] r_state;
   logic       r_last;
   logic [1:0] w_state_nxt;
   logic       w_last_nxt;
   logic       w_arb;
   logic       w_stb_raw;
   logic       w_expire;
   logic       w_resp;
   logic       w_own0;
   logic       w_own1;

   // Re-arbitrate when idle or when the current owner has released cyc.
   always_comb begin
      case (r_state)
         ST_OWN0: w_arb = ~m0_cyc_i;
         ST_OWN1: w_arb = ~m1_cyc_i;
         default: w_arb = 1'b1;
      endcase
   end

   // Round-robin: on contention the master that did not own last wins.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      if (w_arb) begin
         if (m0_cyc_i && m1_cyc_i) begin
            if (r_last) begin
               w_state_nxt = ST_OWN0;
               w_last_nxt  = 1'b0;
            end else begin
               w_state_nxt = ST_OWN1;
               w_last_nxt  = 1'b1;
            end
         end else if (m0_cyc_i) begin
            w_state_nxt = ST_OWN0;
            w_last_nxt  = 1'b0;
         end else if (m1_cyc_i) begin
            w_state_nxt = ST_OWN1;
            w_last_nxt  = 1'b1;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Ownership state and round-robin history.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Owner mux onto the slave; idle drives an all-zero bus.
   always_comb begin
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_we_o    = 1'b0;
      s_cyc_o   = 1'b0;
      w_stb_raw = 1'b0;
      case (r_state)
         ST_OWN0: begin
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            s_sel_o   = m0_sel_i;
            s_we_o    = m0_we_i;
            s_cyc_o   = m0_cyc_i;
            w_stb_raw = m0_stb_i & m0_cyc_i;
         end
         ST_OWN1: begin
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            s_sel_o   = m1_sel_i;
            s_we_o    = m1_we_i;
            s_cyc_o   = m1_cyc_i;
            w_stb_raw = m1_stb_i & m1_cyc_i;
         end
         default: begin
            w_stb_raw = 1'b0;
         end
      endcase
   end

   assign w_resp  = s_ack_i | s_err_i | s_rty_i;
   assign s_stb_o = w_stb_raw & ~w_expire;

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_stb    (w_stb_raw),
      .i_resp   (w_resp),
      .i_clr    (w_state_nxt != r_state),
      .o_expire (w_expire)
   );

   // Responses only reach the owner and only while its strobe is live.
   assign w_own0   = (r_state == ST_OWN0);
   assign w_own1   = (r_state == ST_OWN1);
   assign m0_ack_o = w_own0 & s_ack_i & s_stb_o;
   assign m1_ack_o = w_own1 & s_ack_i & s_stb_o;
   assign m0_err_o = w_own0 & ((s_err_i & s_stb_o) | w_expire);
   assign m1_err_o = w_own1 & ((s_err_i & s_stb_o) | w_expire);
   assign m0_rty_o = w_own0 & s_rty_i & s_stb_o;
   assign m1_rty_o = w_own1 & s_rty_i & s_stb_o;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign gnt_o    = r_state;

endmodule
